// File: rtl/inexrecur_seq_ctrl_if.sv
// Stage handshake bundle between the sequencer (master) and the four
// inexact-recursion stage modules (slave).
interface inexrecur_seq_ctrl_if;
  logic [3:0] stage_go;
  logic [3:0] stage_done;
  logic       is_find;
  logic       is_finish;

  modport master (output stage_go, input stage_done, is_find, is_finish);
  modport slave  (input stage_go, output stage_done, is_find, is_finish);
endinterface

// File: rtl/inexrecur_seq_ctrl.sv
// Inexact-recursion stage sequencer: go/done handshake, per-stage watchdog,
// iteration limit, abort. Define INEXRECUR_PERF_CNT_EN to build the busy/stall counters.
//
// state | meaning
// IDLE  | waiting for start
// PARAM | get-param stage running
// DATA  | get-data stage running
// EX    | ex stage running
// WB    | write-back stage running
// DONE  | one-cycle normal completion
// ERR   | one-cycle error completion
module inexrecur_seq_ctrl #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 4095,
  parameter int TO_W     = 8,
  parameter int STAGE_TO = 200,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  inexrecur_seq_ctrl_if.master stg,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [ITER_W-1:0]    iter_cnt,
  output logic [CNT_W-1:0]     cyc_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PARAM = 3'd1,
    S_DATA  = 3'd2,
    S_EX    = 3'd3,
    S_WB    = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Timeout fires on the cycle whose edge would take the counter to STAGE_TO-1.
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(STAGE_TO - 2);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt;
  logic [1:0]        code_d;
  logic [1:0]        stage_idx;
  logic [3:0]        go_d, go_q;
  logic [ITER_W-1:0] iter_nxt;
  logic              stage_act, stage_hit, timeout, iter_inc, start_acc;

  assign stage_act = state_q inside {S_PARAM, S_DATA, S_EX, S_WB};
  assign stage_idx = state_q[1:0] - 2'd1;
  assign stage_hit = stage_act && stg.stage_done[stage_idx];
  assign timeout   = stage_act && (to_cnt == TO_LAST);
  assign start_acc = (state_q == S_IDLE) && start;
  assign iter_nxt  = iter_cnt + 1'b1;

  assign state        = state_q;
  assign stg.stage_go = go_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      to_cnt   <= '0;
      go_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      iter_cnt <= '0;
    end else begin
      state_q <= state_d;
      to_cnt  <= (state_d != state_q || !stage_act) ? '0 : to_cnt + 1'b1;
      go_q    <= go_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE) || (state_d == S_ERR);
      if (start_acc) begin
        err      <= 1'b0;
        err_code <= 2'd0;
        iter_cnt <= '0;
      end else begin
        if (state_d == S_ERR) begin
          err      <= 1'b1;
          err_code <= code_d;
        end
        if (iter_inc) iter_cnt <= iter_nxt;
      end
    end
  end

  // Priority: abort, then the current stage's done, then the watchdog.
  always_comb begin
    state_d = state_q;
    code_d  = 2'd0;
    case (state_q)
      S_IDLE: if (start) state_d = S_PARAM;
      S_PARAM, S_DATA, S_EX, S_WB: begin
        if (abort) begin
          state_d = S_ERR;
          code_d  = 2'd3;
        end else if (stage_hit) begin
          case (state_q)
            S_PARAM: state_d = stg.is_find ? S_DATA : S_DONE;
            S_DATA:  state_d = S_EX;
            S_EX:    state_d = stg.is_finish ? S_DONE : S_WB;
            default: begin
              if (iter_nxt == ITER_LAST) begin
                state_d = S_ERR;
                code_d  = 2'd2;
              end else begin
                state_d = S_PARAM;
              end
            end
          endcase
        end else if (timeout) begin
          state_d = S_ERR;
          code_d  = 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    go_d = 4'b0000;
    if (state_d != state_q) begin
      case (state_d)
        S_PARAM: go_d = 4'b0001;
        S_DATA:  go_d = 4'b0010;
        S_EX:    go_d = 4'b0100;
        S_WB:    go_d = 4'b1000;
        default: go_d = 4'b0000;
      endcase
    end
    iter_inc = (state_q == S_WB) && stage_hit && !abort;
  end

`ifdef INEXRECUR_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (state_q != S_IDLE && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
      if (state_q == S_DATA && !stg.stage_done[1] && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inexrecur_seq_ctrl.sv
// Bench for inexrecur_seq_ctrl: directed vector table, hand sequences and
// randomized runs checked against a visit-level reference model.
module tb_inexrecur_seq_ctrl;
  localparam int ITER_W   = 16;
  localparam int MAX_ITER = 4;
  localparam int TO_W     = 8;
  localparam int STAGE_TO = 16;
  localparam int CNT_W    = 32;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [2:0]        state;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [ITER_W-1:0] iter_cnt;
  logic [CNT_W-1:0]  cyc_cnt, stall_cnt;

  inexrecur_seq_ctrl_if stg();

  inexrecur_seq_ctrl #(
    .ITER_W(ITER_W), .MAX_ITER(MAX_ITER), .TO_W(TO_W), .STAGE_TO(STAGE_TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stg(stg),
    .state(state), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .iter_cnt(iter_cnt), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Run plan: per-stage, per-occurrence response delay and qualifier values.
  int dly [4][32];
  bit pfind [32];
  bit efin [32];
  int abort_at;
  bit rand_start;

  int m_code, m_iter, m_busy, m_stall;
  int m_vis[$];
  int r_vis[$];

  typedef struct {
    string name;
    int n_find; int fin_ex; int d; int dd; int ab;
    int code; int iter; int busy; int stall;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int go_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Walks the plan one stage visit at a time; a visit lasts delay+1 cycles,
  // or STAGE_TO-1 cycles when the answer would come too late.
  task automatic model();
    int s, o, d, len, c0, j;
    int occ[4];
    bit to, fin;
    occ = '{0, 0, 0, 0};
    s = 0; c0 = 0; fin = 0;
    m_code = 0; m_iter = 0; m_stall = 0;
    m_vis.delete();
    while (!fin) begin
      o = occ[s];
      occ[s]++;
      m_vis.push_back(s);
      d   = dly[s][o];
      to  = (d > STAGE_TO - 2);
      len = to ? STAGE_TO - 1 : d + 1;
      if (abort_at >= c0 && abort_at < c0 + len) begin
        j = abort_at - c0;
        if (s == 1) m_stall += (to || j < d) ? j + 1 : d;
        m_code = 3;
        c0 = abort_at + 1;
        fin = 1;
      end else begin
        if (s == 1) m_stall += to ? len : d;
        c0 += len;
        if (to) begin
          m_code = 1;
          fin = 1;
        end else begin
          case (s)
            0: if (pfind[o]) s = 1; else fin = 1;
            1: s = 2;
            2: if (efin[o]) fin = 1; else s = 3;
            default: begin
              m_iter++;
              if (m_iter == MAX_ITER) begin m_code = 2; fin = 1; end
              else s = 0;
            end
          endcase
        end
      end
    end
    m_busy = c0 + 1;
  endtask

  task automatic fill_plan(input int n_find, input int fin_ex, input int d, input int dd, input int ab);
    for (int i = 0; i < 32; i++) begin
      pfind[i] = (i < n_find);
      efin[i]  = (i == fin_ex);
      for (int s = 0; s < 4; s++) dly[s][i] = (s == 1) ? dd : d;
    end
    abort_at   = ab;
    rand_start = 0;
  endtask

  task automatic run_plan(input string tag, input int e_code, input int e_iter,
                          input int e_busy, input int e_stall);
    int s, o, cnt, cyc, mm, r_done_n, r_code, r_err, r_iter, r_state;
    int occ[4];
    bit active;
    model();
    occ = '{0, 0, 0, 0};
    r_vis.delete();
    s = 0; o = 0; cnt = 0; active = 0; r_done_n = 0;
    r_code = -1; r_err = -1; r_iter = -1; r_state = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("%s err cleared", tag), err, 0);
    chk($sformatf("%s err_code cleared", tag), err_code, 0);
    chk($sformatf("%s iter cleared", tag), iter_cnt, 0);
    for (cyc = 0; cyc < 3000 && busy; cyc++) begin
      if (stg.stage_go != 4'd0) begin
        s = go_idx(stg.stage_go);
        r_vis.push_back(($countones(stg.stage_go) == 1 && state == 3'(s + 1)) ? s : 9);
        o = occ[s];
        occ[s]++;
        cnt = 0;
        active = 1;
      end
      if (done) begin
        r_done_n++;
        r_code = err_code; r_err = err; r_iter = iter_cnt; r_state = state;
        active = 0;
      end
      abort = active && (cyc == abort_at);
      start = rand_start && ($urandom_range(0, 3) == 0);
      stg.is_find    = 1'($urandom);
      stg.is_finish  = 1'($urandom);
      stg.stage_done = active ? (4'($urandom) & ~(4'b0001 << s)) : 4'b0000;
      if (active && cnt == dly[s][o]) begin
        stg.stage_done[s] = 1'b1;
        if (s == 0) stg.is_find   = pfind[o];
        if (s == 2) stg.is_finish = efin[o];
      end
      cnt++;
      @(posedge clk); #1;
    end
    abort = 0; start = 0;
    stg.stage_done = 4'd0; stg.is_find = 0; stg.is_finish = 0;
    chk($sformatf("%s run bound busy", tag), busy, 0);
    mm = (r_vis.size() == m_vis.size()) ? -1 : r_vis.size();
    for (int i = 0; i < r_vis.size() && i < m_vis.size(); i++)
      if (mm == -1 && r_vis[i] != m_vis[i]) mm = i;
    chk($sformatf("%s visit sequence first bad index", tag), mm, -1);
    chk($sformatf("%s busy cycles", tag), cyc, e_busy);
    chk($sformatf("%s done pulses", tag), r_done_n, 1);
    chk($sformatf("%s end state", tag), r_state, (e_code == 0) ? 5 : 6);
    chk($sformatf("%s err_code", tag), r_code, e_code);
    chk($sformatf("%s err", tag), r_err, (e_code != 0));
    chk($sformatf("%s iter_cnt", tag), r_iter, e_iter);
`ifdef INEXRECUR_PERF_CNT_EN
    chk($sformatf("%s cyc_cnt", tag), cyc_cnt, e_busy);
    chk($sformatf("%s stall_cnt", tag), stall_cnt, e_stall);
`else
    chk($sformatf("%s cyc_cnt", tag), cyc_cnt, 0);
    chk($sformatf("%s stall_cnt", tag), stall_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("%s idle state", tag), state, 0);
    chk($sformatf("%s err held", tag), err, (e_code != 0));
    chk($sformatf("%s err_code held", tag), err_code, e_code);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    tbl[0] = '{"normal",       3, -1,  1,  1, -1, 0, 3, 27,  3};
    tbl[1] = '{"finish_ex",   99,  0,  1,  1, -1, 0, 0,  7,  1};
    tbl[2] = '{"no_find",      0, -1,  0,  0, -1, 0, 0,  2,  0};
    tbl[3] = '{"timeout_data", 1, -1,  0, 99, -1, 1, 0, 17, 15};
    tbl[4] = '{"iter_limit",  99, -1,  0,  0, -1, 2, 4, 17,  0};
    tbl[5] = '{"abort_ex",    99, -1,  0,  0,  2, 3, 0,  4,  0};
    tbl[6] = '{"stall_cnt",    2, -1,  0,  3, -1, 0, 2, 16,  6};
    tbl[7] = '{"abort_wb",    99, -1,  2,  2, 10, 3, 0, 12,  2};
    tbl[8] = '{"to_edge_ok",   0, -1, 14,  0, -1, 0, 0, 16,  0};
    tbl[9] = '{"to_edge_err",  0, -1, 15,  0, -1, 1, 0, 16,  0};

    rst = 1; start = 0; abort = 0;
    stg.stage_done = 4'd0; stg.is_find = 0; stg.is_finish = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", state, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset err_code", err_code, 0);
    chk("reset iter_cnt", iter_cnt, 0);
    chk("reset stage_go", stg.stage_go, 0);
    chk("reset cyc_cnt", cyc_cnt, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    rst = 0;

    abort = 1;
    repeat (3) @(posedge clk);
    #1;
    abort = 0;
    chk("abort in idle state", state, 0);
    chk("abort in idle busy", busy, 0);
    chk("abort in idle err", err, 0);

    for (int i = 0; i < 10; i++) begin
      fill_plan(tbl[i].n_find, tbl[i].fin_ex, tbl[i].d, tbl[i].dd, tbl[i].ab);
      run_plan(tbl[i].name, tbl[i].code, tbl[i].iter, tbl[i].busy, tbl[i].stall);
    end

    // Synchronous reset in the middle of a run: straight to IDLE, no done pulse.
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    stg.stage_done = 4'b0001; stg.is_find = 1;
    @(posedge clk); #1;
    stg.stage_done = 4'b0000; stg.is_find = 0;
    chk("midrun in data", state, 2);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrun reset state", state, 0);
    chk("midrun reset busy", busy, 0);
    chk("midrun reset done", done, 0);
    chk("midrun reset stage_go", stg.stage_go, 0);
    @(posedge clk); #1;
    chk("midrun no done after reset", done, 0);
    chk("midrun stays idle", state, 0);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 32; i++) begin
        pfind[i] = ($urandom_range(0, 99) < 85);
        efin[i]  = ($urandom_range(0, 99) < 15);
        for (int s = 0; s < 4; s++) begin
          r = $urandom_range(0, 99);
          dly[s][i] = (r < 85) ? $urandom_range(0, 3) :
                      (r < 95) ? $urandom_range(4, 14) : $urandom_range(15, 30);
        end
      end
      abort_at   = ($urandom_range(0, 99) < 20) ? $urandom_range(0, 60) : -1;
      rand_start = 1;
      model();
      run_plan($sformatf("rand%0d", n), m_code, m_iter, m_busy, m_stall);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
